interp_phase_gen: RTL

- Upstream feeder for the post-processing linear interpolator: a fractional resampler address generator.
- Consumes a framed input sample stream and runs a fixed-point phase accumulator driven by a programmable step.
- For each output position x it emits the bracketing pair (y0 at x0, y1 at x1 = x0+1) plus the distance terms the interpolator needs.
- The interpolator has no backpressure, so this block throttles its input instead.

---
 rtl/interp_pkg.sv | 35 +++
 rtl/interp_phase_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/interp_pkg.sv
// Shared types and helpers for the fractional resampler address generator.
package interp_pkg;

    localparam int FORMAT_DEF = 8;
    localparam int ONE        = 2 ** FORMAT_DEF;
    localparam int SAT_W      = 32;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    // Difference a - b computed one bit wider, clamped to a signed range of 'width' bits (width <= SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_sub(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      width
    );
        logic signed [SAT_W:0] diff;
        logic signed [SAT_W:0] one_v;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        one_v = {{SAT_W{1'b0}}, 1'b1};
        diff  = {a[SAT_W-1], a} - {b[SAT_W-1], b};
        hi    = (one_v <<< (width - 1)) - one_v;
        lo    = ~hi;
        if (diff > hi) begin
            return hi[SAT_W-1:0];
        end else if (diff < lo) begin
            return lo[SAT_W-1:0];
        end
        return diff[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/interp_phase_gen.sv
// Fractional resampler address generator: holds a two-sample window and steps a
// fixed-point phase across it, emitting (y0, y1-y0, frac, ONE-frac) per output position.
module interp_phase_gen
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FORMAT     = FORMAT_DEF,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [USER_WIDTH-1:0] s_user,
    input  logic                  s_last,
    input  logic                  s_vld,
    output logic                  s_rdy,
    output logic [DATA_WIDTH-1:0] x_sub_x0,
    output logic [DATA_WIDTH-1:0] x_sub_x1,
    output logic [DATA_WIDTH-1:0] y1_sub_y0,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [USER_WIDTH-1:0] user_o,
    output logic                  vld_o
);

    localparam int                    NEED_W = DATA_WIDTH + 1 - FORMAT;
    localparam logic [DATA_WIDTH-1:0] ONE_W  = DATA_WIDTH'(1) << FORMAT;

    state_t                state_q, state_d;
    logic                  fill_q, fill_d;     // one sample held while filling
    logic [FORMAT-1:0]     frac_q, frac_d;
    logic [NEED_W-1:0]     need_q, need_d;     // samples still to consume before the next emit
    logic                  last_q, last_d;
    logic                  shift;
    logic                  emit;
    logic [DATA_WIDTH-1:0] step_eff;
    logic [DATA_WIDTH:0]   pos;

    logic [DATA_WIDTH-1:0] w0_data, w1_data;
    logic [USER_WIDTH-1:0] w0_user, w1_user;

    // A zero step would never advance; it is promoted to one LSB.
    assign step_eff = (step == '0) ? DATA_WIDTH'(1) : step;
    assign pos      = {1'b0, step_eff} + (DATA_WIDTH + 1)'(frac_q);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        frac_d  = frac_q;
        need_d  = need_q;
        last_d  = last_q;
        s_rdy   = 1'b0;
        shift   = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            FILL: begin
                s_rdy = 1'b1;
                if (s_vld) begin
                    shift = 1'b1;
                    if (!fill_q) begin
                        // A frame ending on its first sample cannot form a pair; drop it.
                        fill_d = !s_last;
                    end else begin
                        state_d = RUN;
                        fill_d  = 1'b0;
                        frac_d  = '0;
                        need_d  = '0;
                        last_d  = s_last;
                    end
                end
            end
            RUN: begin
                if (need_q != '0) begin
                    if (last_q) begin
                        // Frame exhausted before the next position is bracketed.
                        state_d = FILL;
                        fill_d  = 1'b0;
                        frac_d  = '0;
                        need_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        s_rdy = 1'b1;
                        if (s_vld) begin
                            shift  = 1'b1;
                            need_d = need_q - NEED_W'(1);
                            last_d = s_last;
                        end
                    end
                end else begin
                    emit   = 1'b1;
                    frac_d = pos[FORMAT-1:0];
                    need_d = pos[DATA_WIDTH:FORMAT];
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= 1'b0;
            frac_q  <= '0;
            need_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            frac_q  <= frac_d;
            need_q  <= need_d;
            last_q  <= last_d;
        end
    end

    // NOTE: the window is only two registers, so it is reset with the control state rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_data <= '0;
            w1_data <= '0;
            w0_user <= '0;
            w1_user <= '0;
        end else if (shift) begin
            w0_data <= w1_data;
            w0_user <= w1_user;
            w1_data <= s_data;
            w1_user <= s_user;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_o     <= 1'b0;
            y0        <= '0;
            y1_sub_y0 <= '0;
            x_sub_x0  <= '0;
            x_sub_x1  <= '0;
            user_o    <= '0;
        end else begin
            vld_o <= emit;
            if (emit) begin
                y0        <= w0_data;
                user_o    <= w0_user;
                x_sub_x0  <= DATA_WIDTH'(frac_q);
                x_sub_x1  <= ONE_W - DATA_WIDTH'(frac_q);
                y1_sub_y0 <= DATA_WIDTH'(sat_sub(SAT_W'(signed'(w1_data)),
                                                 SAT_W'(signed'(w0_data)),
                                                 DATA_WIDTH));
            end
        end
    end

endmodule
